// File: rtl/tb_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, controller
// states and the alignment rule.
package tb_pkg;

    localparam int DATA_ADDR_WIDTH = 32;
    localparam int DATA_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_DATA,
        ST_WR,
        RMW_RD,
        RMW_WR,
        ERR
    } lsu_state_e;

    // Size 2'b11 is reserved and never legal.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~lane[0];
            MEM_WORD: return (lane == 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for a 32-bit word memory: load extraction with sign/zero
// extension, and sub-word merge for read-modify-write stores.
module lsu_lane_align
    import tb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_mem_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    assign w_byte = i_mem_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{i_lane[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_load_data  = i_mem_rdata;
        o_merge_data = i_wdata;
        w_sign       = 1'b0;
        case (i_size)
            MEM_BYTE: begin
                w_sign       = ~i_unsigned & w_byte[7];
                o_load_data  = {{24{w_sign}}, w_byte};
                o_merge_data = i_mem_rdata;
                o_merge_data[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            MEM_HALF: begin
                w_sign       = ~i_unsigned & w_half[15];
                o_load_data  = {{16{w_sign}}, w_half};
                o_merge_data = i_mem_rdata;
                o_merge_data[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one outstanding access, sub-word stores done as
// read-modify-write, misaligned or reserved-size requests answered with err_o.
module lsu_mem_ctrl
    import tb_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_ADDR_WIDTH,
    parameter int DATA_WIDTH = DATA_WORD_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            r_state;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rvalid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge_data;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    lsu_lane_align u_lane_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_lane       (r_addr[1:0]),
        .i_mem_rdata  (mem_rdata_i),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign ready_o     = (r_state == IDLE);
    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_size     <= size_i;
                        r_unsigned <= unsigned_i;
                        r_addr     <= addr_i;
                        r_wdata    <= wdata_i;
                        if (!is_legal(size_i, addr_i[1:0])) r_state <= ERR;
                        else if (!we_i)                     r_state <= LD_REQ;
                        else if (size_i == MEM_WORD)        r_state <= ST_WR;
                        else                                r_state <= RMW_RD;
                    end
                end
                LD_REQ:  r_state <= LD_DATA;
                LD_DATA: begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_load_data;
                    r_state  <= IDLE;
                end
                ST_WR, RMW_WR: begin
                    r_rvalid <= 1'b1;
                    r_state  <= IDLE;
                end
                RMW_RD:  r_state <= RMW_WR;
                ERR: begin
                    r_rvalid <= 1'b1;
                    r_err    <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decoded from state so an asserted reset drops the strobe before the edge.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            LD_REQ, RMW_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = w_word_addr;
            end
            ST_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = w_word_addr;
                mem_wdata_o = r_wdata;
            end
            RMW_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = w_word_addr;
                mem_wdata_o = w_merge_data;
            end
            default: ;
        endcase
    end

endmodule
